// File: rtl/multicycle_decoder_pkg.sv
// Shared opcode map, ALU function codes, control FSM states and the static
// decode fields for the multi-cycle instruction decoder.
package multicycle_decoder_pkg;

    // The low three opcode bits double as the ALU function select
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_MLT  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_SUBI = 6'h0A;
    localparam logic [5:0] OP_MLTI = 6'h0B;
    localparam logic [5:0] OP_BEQ  = 6'h10;
    localparam logic [5:0] OP_JMP  = 6'h11;
    localparam logic [5:0] OP_LD   = 6'h20;
    localparam logic [5:0] OP_ST   = 6'h21;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MUL  = 3'd3;

    typedef enum logic [1:0] {
        EXEC     = 2'd0,
        MUL_WAIT = 2'd1,
        IN_WAIT  = 2'd2,
        OUT_WAIT = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic arith;
        logic immediate;
        logic is_mul;
        logic is_ld;
        logic is_st;
        logic is_branch;
        logic is_jmp;
        logic illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/multicycle_decoder_opcode_decode.sv
// Pure combinational opcode decode into the static control fields; timing and
// handshaking are layered on top by the control FSM.
module opcode_decode
    import multicycle_decoder_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output dec_ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPCODE_W'(OP_NOP): ctrl = '0;
            OPCODE_W'(OP_ADD),
            OPCODE_W'(OP_SUB): ctrl.arith = 1'b1;
            OPCODE_W'(OP_MLT): begin
                ctrl.arith  = 1'b1;
                ctrl.is_mul = 1'b1;
            end
            OPCODE_W'(OP_ADDI),
            OPCODE_W'(OP_SUBI): begin
                ctrl.arith     = 1'b1;
                ctrl.immediate = 1'b1;
            end
            OPCODE_W'(OP_MLTI): begin
                ctrl.arith     = 1'b1;
                ctrl.immediate = 1'b1;
                ctrl.is_mul    = 1'b1;
            end
            OPCODE_W'(OP_BEQ): ctrl.is_branch = 1'b1;
            OPCODE_W'(OP_JMP): ctrl.is_jmp    = 1'b1;
            OPCODE_W'(OP_LD):  ctrl.is_ld     = 1'b1;
            OPCODE_W'(OP_ST):  ctrl.is_st     = 1'b1;
            default:           ctrl.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_decoder.sv
// Instruction decoder with a control FSM for multi-cycle multiply and
// valid/ready I/O, a registered zero flag and a sticky illegal-opcode flag.
//
// state    | meaning
// EXEC     | issue current opcode; single-cycle ops complete here
// MUL_WAIT | multiply in flight, down-counter runs to terminal count 0
// IN_WAIT  | LD stalled until in_valid
// OUT_WAIT | ST stalled until out_ready
module multicycle_decoder
    import multicycle_decoder_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int ALU_FUNC_W = 3,
    parameter int MLT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  alu_zf,
    input  logic                  in_valid,
    input  logic                  out_ready,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  pc_en,
    output logic                  pc_rel_branch,
    output logic                  reg_write,
    output logic                  immediate,
    output logic                  read_in,
    output logic                  in_ready,
    output logic                  write_out,
    output logic                  out_valid,
    output logic                  zf,
    output logic                  illegal_op
);

    localparam int CNT_W = (MLT_CYCLES > 1) ? $clog2(MLT_CYCLES) : 1;
    // The EXEC cycle and the terminal-count cycle both count toward latency
    localparam logic [CNT_W-1:0] CNT_LOAD = (MLT_CYCLES > 1) ? CNT_W'(MLT_CYCLES - 2) : '0;
    localparam logic MULTI_CYCLE_MUL = (MLT_CYCLES > 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zf_q, zf_d;
    logic             illegal_q, illegal_d;
    dec_ctrl_t        dec;

    opcode_decode #(.OPCODE_W(OPCODE_W)) u_opcode_decode (
        .opcode (opcode),
        .ctrl   (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EXEC;
            cnt_q     <= '0;
            zf_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            zf_q      <= zf_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        illegal_d     = illegal_q;
        alu_func      = '0;
        pc_en         = 1'b0;
        pc_rel_branch = 1'b0;
        reg_write     = 1'b0;
        immediate     = 1'b0;
        read_in       = 1'b0;
        in_ready      = 1'b0;
        write_out     = 1'b0;
        out_valid     = 1'b0;

        if (!reset) begin
            alu_func = opcode[ALU_FUNC_W-1:0];
            case (state_q)
                EXEC: begin
                    immediate = dec.immediate;
                    if (dec.is_mul && MULTI_CYCLE_MUL) begin
                        cnt_d   = CNT_LOAD;
                        state_d = MUL_WAIT;
                    end else if (dec.is_ld) begin
                        read_in = 1'b1;
                        if (in_valid) begin
                            reg_write = 1'b1;
                            in_ready  = 1'b1;
                            pc_en     = 1'b1;
                        end else begin
                            state_d = IN_WAIT;
                        end
                    end else if (dec.is_st) begin
                        out_valid = 1'b1;
                        if (out_ready) begin
                            write_out = 1'b1;
                            pc_en     = 1'b1;
                        end else begin
                            state_d = OUT_WAIT;
                        end
                    end else begin
                        // Unknown opcodes fall through here as a NOP
                        pc_en         = 1'b1;
                        reg_write     = dec.arith;
                        pc_rel_branch = dec.is_jmp | (dec.is_branch & zf_q);
                        illegal_d     = illegal_q | dec.illegal;
                    end
                end
                MUL_WAIT: begin
                    immediate = dec.immediate;
                    if (cnt_q == '0) begin
                        reg_write = 1'b1;
                        pc_en     = 1'b1;
                        state_d   = EXEC;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                IN_WAIT: begin
                    read_in = 1'b1;
                    if (in_valid) begin
                        reg_write = 1'b1;
                        in_ready  = 1'b1;
                        pc_en     = 1'b1;
                        state_d   = EXEC;
                    end
                end
                OUT_WAIT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        write_out = 1'b1;
                        pc_en     = 1'b1;
                        state_d   = EXEC;
                    end
                end
                default: state_d = EXEC;
            endcase
        end

        zf_d = (reg_write && !read_in) ? alu_zf : zf_q;
    end

    assign zf         = zf_q & ~reset;
    assign illegal_op = illegal_q & ~reset;

endmodule
